// File: rtl/edge_pkg.sv
// Shared edge-mode encodings and a width helper for the multi-channel edge detector.
package edge_pkg;

   localparam logic [1:0] EDGE_RISE = 2'd0;
   localparam logic [1:0] EDGE_FALL = 2'd1;
   localparam logic [1:0] EDGE_BOTH = 2'd2;

   // Bits needed to represent values 0..val-1; a bounded loop keeps it elaboration-friendly.
   function automatic int unsigned clog2(input int unsigned val);
      int unsigned res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(val)) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser, counter debounce, registered edge pulses and sticky flag.
module edge_channel
   import edge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic [1:0]  EDGE_MODE       = EDGE_RISE
) (
   input  logic clk,
   input  logic rstN,
   input  logic sigIn,
   input  logic en,
   input  logic evtClr,
   output logic level,
   output logic rise,
   output logic fall,
   output logic pulse,
   output logic evtFlag
);

   localparam int unsigned      CNT_W   = clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   pulse_q, pulse_d;
   logic                   flag_q, flag_d;
   logic                   synced;
   logic                   accept;
   logic                   edge_sel;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], sigIn};
   assign synced = sync_q[SYNC_STAGES-1];

   // Any cycle where synced matches the stable level discards the pending count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      accept  = 1'b0;
      if (synced == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         accept  = 1'b1;
         level_d = synced;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      rise_d = accept & synced;
      fall_d = accept & ~synced;
      case (EDGE_MODE)
         EDGE_RISE: edge_sel = rise_d;
         EDGE_FALL: edge_sel = fall_d;
         default:   edge_sel = rise_d | fall_d;
      endcase
      pulse_d = edge_sel & en;
      flag_d  = pulse_d | (flag_q & ~evtClr);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         pulse_q <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         pulse_q <= pulse_d;
         flag_q  <= flag_d;
      end
   end

   assign level   = level_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign pulse   = pulse_q;
   assign evtFlag = flag_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Array of independent debounced edge-detector channels for raw asynchronous inputs.
module multi_edge_detector
   import edge_pkg::*;
#(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic [1:0]  EDGE_MODE       = EDGE_RISE
) (
   input  logic                clk,
   input  logic                rstN,
   input  logic [CHANNELS-1:0] sigIn,
   input  logic [CHANNELS-1:0] en,
   input  logic [CHANNELS-1:0] evtClr,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] pulse,
   output logic [CHANNELS-1:0] evtFlag
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      edge_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .EDGE_MODE      (EDGE_MODE)
      ) u_ch (
         .clk    (clk),
         .rstN   (rstN),
         .sigIn  (sigIn[g]),
         .en     (en[g]),
         .evtClr (evtClr[g]),
         .level  (level[g]),
         .rise   (rise[g]),
         .fall   (fall[g]),
         .pulse  (pulse[g]),
         .evtFlag(evtFlag[g])
      );
   end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: rise-mode, both-mode and minimal-filter instances against hand-computed vectors.
module tb_multi_edge_detector;

   logic       clk;
   logic       rstN;
   logic [3:0] sig, en, clr, sig_c;
   logic [3:0] lr, rr, fr, pr, flr;
   logic [3:0] lb, rb, fb, pb, flb;
   logic [3:0] l1, r1, f1, p1, fl1;

   int total = 0;
   int passed = 0;

   multi_edge_detector #(
      .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2'd0)
   ) dut_r (
      .clk(clk), .rstN(rstN), .sigIn(sig), .en(en), .evtClr(clr),
      .level(lr), .rise(rr), .fall(fr), .pulse(pr), .evtFlag(flr)
   );

   multi_edge_detector #(
      .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2'd2)
   ) dut_b (
      .clk(clk), .rstN(rstN), .sigIn(sig), .en(en), .evtClr(clr),
      .level(lb), .rise(rb), .fall(fb), .pulse(pb), .evtFlag(flb)
   );

   multi_edge_detector #(
      .CHANNELS(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_MODE(2'd0)
   ) dut_1 (
      .clk(clk), .rstN(rstN), .sigIn(sig_c), .en(4'hF), .evtClr(4'h0),
      .level(l1), .rise(r1), .fall(f1), .pulse(p1), .evtFlag(fl1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         n;
      logic [3:0] sig, en, clr, lvl, rs, fl, pl, fg;
   } vec_t;

   vec_t tbl[23];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstN  = 1'b1;
      sig   = 4'h0;
      en    = 4'hF;
      clr   = 4'h0;
      sig_c = 4'h0;
      #2 rstN = 1'b0;
      #1;
      chk("reset_state", {lr, rr, fr, pr, flr, lb, rb, fb, pb, flb, l1, r1, f1, p1, fl1}, 0);
      tick();
      tick();
      chk("reset_hold", {lr, rr, fr, pr, flr}, 0);
      rstN = 1'b1;

      //           n  sig      en       clr      lvl      rise     fall     pulse    flag
      tbl[0]  = '{5, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[1]  = '{1, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
      tbl[2]  = '{1, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      tbl[3]  = '{3, 4'b0011, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      tbl[4]  = '{1, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      tbl[5]  = '{1, 4'b0001, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[6]  = '{1, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[7]  = '{5, 4'b0011, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[8]  = '{1, 4'b0011, 4'b1111, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
      tbl[9]  = '{1, 4'b0011, 4'b1111, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[10] = '{5, 4'b1011, 4'b0111, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[11] = '{1, 4'b1011, 4'b0111, 4'b0000, 4'b1011, 4'b1000, 4'b0000, 4'b0000, 4'b0010};
      tbl[12] = '{1, 4'b1011, 4'b0111, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[13] = '{5, 4'b0011, 4'b1111, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[14] = '{1, 4'b0011, 4'b1111, 4'b0000, 4'b0011, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
      tbl[15] = '{1, 4'b0011, 4'b1111, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[16] = '{5, 4'b1011, 4'b1111, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[17] = '{1, 4'b1011, 4'b1111, 4'b1000, 4'b1011, 4'b1000, 4'b0000, 4'b1000, 4'b1010};
      tbl[18] = '{1, 4'b1011, 4'b1111, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[19] = '{1, 4'b1011, 4'b1111, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[20] = '{5, 4'b1000, 4'b1111, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[21] = '{1, 4'b1000, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0010};
      tbl[22] = '{2, 4'b1000, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};

      for (int i = 0; i < 23; i++) begin
         for (int c = 0; c < tbl[i].n; c++) begin
            @(negedge clk);
            sig = tbl[i].sig;
            en  = tbl[i].en;
            clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl[%0d].%0d", i, c), {12'h0, lr, rr, fr, pr, flr},
                {12'h0, tbl[i].lvl, tbl[i].rs, tbl[i].fl, tbl[i].pl, tbl[i].fg});
         end
      end
      en  = 4'hF;
      clr = 4'h0;

      // Both-edge instance: ch2 held 10 cycles then released.
      sig = 4'b1100;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("b_press_wait", {rb[2], pb[2]}, 0);
      end
      tick();
      chk("b_rise", {rb[2], fb[2], pb[2], flb[2]}, 4'b1011);
      chk("r_rise2", {rr[2], pr[2]}, 2'b11);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("b_hold", {pb[2], lb[2], flb[2]}, 3'b011);
      end
      sig = 4'b1000;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("b_rel_wait", {pb[2], lb[2]}, 2'b01);
      end
      tick();
      chk("b_fall", {rb[2], fb[2], pb[2], flb[2], lb[2]}, 5'b01110);
      chk("r_fall2_nopulse", {fr[2], pr[2]}, 2'b10);
      tick();
      chk("b_after", {pb[2], flb[2]}, 2'b01);

      // Inputs held high through reset report one press after release.
      sig = 4'hF;
      tick();
      tick();
      rstN = 1'b0;
      #1;
      chk("rst_async", {lr, rr, fr, pr, flr, lb, rb, fb, pb, flb}, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_low", {lr, rr, fr, pr, flr, lb, rb, fb, pb, flb}, 0);
      end
      rstN = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("rel_wait", {lr, rr}, 0);
      end
      tick();
      chk("rel_rise", {lr, rr, pr, flr}, 16'hFFFF);
      tick();
      chk("rel_after", {lr, rr}, 8'hF0);

      sig = 4'h0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("all_fall_wait", {lr, fr}, 8'hF0);
      end
      tick();
      chk("all_fall", {lr, fr, pr, flr}, 16'h0F0F);

      // Reset pulse mid-count: filtering restarts from scratch.
      sig = 4'b0001;
      for (int c = 0; c < 4; c++) tick();
      rstN = 1'b0;
      #2 rstN = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("midrst_wait", {lr[0], rr[0]}, 0);
      end
      tick();
      chk("midrst_rise", {lr[0], rr[0]}, 2'b11);

      // Minimal-filter instance: three sync stages, no debounce.
      sig_c = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("d1_step_wait", {l1[0], r1[0]}, 0);
      end
      tick();
      chk("d1_step_rise", {l1[0], r1[0]}, 2'b11);
      tick();
      chk("d1_step_after", {l1[0], r1[0]}, 2'b10);

      sig_c = 4'b0011;
      tick();
      sig_c = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("d1_glitch_wait", {l1[1], r1[1], f1[1]}, 0);
      end
      tick();
      chk("d1_glitch_rise", {l1[1], r1[1], f1[1], p1[1]}, 4'b1101);
      tick();
      chk("d1_glitch_fall", {l1[1], r1[1], f1[1], p1[1]}, 4'b0010);
      tick();
      chk("d1_glitch_idle", {l1[1], r1[1], f1[1], l1[0]}, 4'b0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
